// File: rtl/uart_tx_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : uart_tx_serializer                                            |
// | Description: UART frame serializer (start, data, optional parity, stop)   |
// |              paced by an external baud_tick enable.                       |
// | Revision   : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module uart_tx_serializer #(
  parameter int DATA_WIDTH  = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int MSB_FIRST   = 0
) (
  input  logic                  tx_clk,
  input  logic                  rst,
  input  logic                  baud_tick,
  input  logic                  tx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_ready,
  output logic                  serial_out,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int                CNT_W      = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT   = CNT_W'(DATA_WIDTH);
  localparam logic              HAS_PARITY = (PARITY_MODE != 0);
  localparam logic              ODD_PARITY = (PARITY_MODE == 2);
  localparam logic              LAST_STOP  = (STOP_BITS == 2);

  generate
    if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
      $error("uart_tx_serializer: DATA_WIDTH must be 5..9");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
      $error("uart_tx_serializer: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
    end
    if (MSB_FIRST < 0 || MSB_FIRST > 1) begin : g_bad_order
      $error("uart_tx_serializer: MSB_FIRST must be 0 or 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP   = 3'd5
  } state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic                  stop_cnt_q;
  logic                  parity_q;
  logic                  serial_q;
  logic                  done_q;

  logic                  parity_d;
  logic                  data_bit_d;
  logic [DATA_WIDTH-1:0] shift_d;

  assign parity_d = (^tx_data) ^ ODD_PARITY;

  // The bit presented next always sits at the outgoing end of the shifter.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign data_bit_d = shift_q[DATA_WIDTH-1];
      assign shift_d    = {shift_q[DATA_WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign data_bit_d = shift_q[0];
      assign shift_d    = {1'b0, shift_q[DATA_WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge tx_clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      parity_q   <= 1'b0;
      serial_q   <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (tx_valid) begin
            shift_q    <= tx_data;
            parity_q   <= parity_d;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            state_q    <= S_ARM;
          end
        end
        S_ARM: begin
          if (baud_tick) begin
            serial_q <= 1'b0;
            state_q  <= S_START;
          end
        end
        S_START: begin
          if (baud_tick) begin
            serial_q  <= data_bit_d;
            shift_q   <= shift_d;
            bit_cnt_q <= CNT_W'(1);
            state_q   <= S_DATA;
          end
        end
        S_DATA: begin
          if (baud_tick) begin
            if (bit_cnt_q == LAST_BIT) begin
              if (HAS_PARITY) begin
                serial_q <= parity_q;
                state_q  <= S_PARITY;
              end else begin
                serial_q <= 1'b1;
                state_q  <= S_STOP;
              end
            end else begin
              serial_q  <= data_bit_d;
              shift_q   <= shift_d;
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (baud_tick) begin
            serial_q <= 1'b1;
            state_q  <= S_STOP;
          end
        end
        S_STOP: begin
          if (baud_tick) begin
            if (stop_cnt_q == LAST_STOP) begin
              state_q   <= S_IDLE;
              done_q    <= 1'b1;
              bit_cnt_q <= '0;
            end else begin
              stop_cnt_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q  <= S_IDLE;
          serial_q <= 1'b1;
        end
      endcase
    end
  end

  assign tx_ready   = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign serial_out = serial_q;
  assign frame_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_uart_tx_serializer                                         |
// | Description: Bench for uart_tx_serializer over six parameter sets.        |
// | Revision   : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_uart_tx_serializer;

  localparam int NCFG  = 6;
  localparam int LIMIT = 3000;
  localparam int CW [0:NCFG-1] = '{8, 8, 8, 8, 5, 9};
  localparam int CP [0:NCFG-1] = '{0, 1, 2, 0, 0, 2};
  localparam int CS [0:NCFG-1] = '{1, 1, 1, 2, 1, 2};
  localparam int CM [0:NCFG-1] = '{0, 0, 0, 1, 0, 1};

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            tick = 1'b0;
  logic [NCFG-1:0] valid = '0;
  logic [8:0]      data = '0;
  int              tick_per = 4;
  int              tick_cnt = 0;
  int              errors = 0;
  int              checks = 0;
  int              base_acc [0:NCFG-1];

  logic [NCFG-1:0] so_v, rdy_v, bsy_v, dn_v;
  logic [NCFG-1:0] eline_v, ebusy_v, edone_v;
  logic [7:0]      acc_v [0:NCFG-1];

  always #5 clk = ~clk;

  // Frame as the line shows it: bit k of the result is the k-th bit period.
  function automatic logic [15:0] frame_bits(input int w, input int pm, input int sb,
                                             input int mf, input logic [8:0] d);
    logic [15:0] f;
    logic        p;
    int          k;
    f = '0;
    p = 1'b0;
    k = 1;
    for (int b = 0; b < w; b++) begin
      f[k] = (mf != 0) ? d[w-1-b] : d[b];
      p    = p ^ d[b];
      k++;
    end
    if (pm != 0) begin
      f[k] = (pm == 2) ? ~p : p;
      k++;
    end
    for (int s = 0; s < sb; s++) begin
      f[k] = 1'b1;
      k++;
    end
    return f;
  endfunction

  function automatic int frame_len(input int w, input int pm, input int sb);
    return 1 + w + ((pm != 0) ? 1 : 0) + sb;
  endfunction

  function automatic logic frame_bit(input int w, input int pm, input int sb, input int mf,
                                     input logic [8:0] d, input int k);
    logic [15:0] f;
    f = frame_bits(w, pm, sb, mf, d);
    return f[k];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
    localparam int W = CW[gi];
    logic         so, rdy, bsy, dn;
    logic [W-1:0] dw;
    bit           q[$];
    logic         m_busy = 1'b0;
    logic         m_line = 1'b1;
    logic         m_done = 1'b0;
    logic [7:0]   acc_cnt = '0;
    int           pop_cnt = 0;

    assign dw = data[W-1:0];

    uart_tx_serializer #(
      .DATA_WIDTH (W),
      .PARITY_MODE(CP[gi]),
      .STOP_BITS  (CS[gi]),
      .MSB_FIRST  (CM[gi])
    ) u_dut (
      .tx_clk    (clk),
      .rst       (rst),
      .baud_tick (tick),
      .tx_valid  (valid[gi]),
      .tx_data   (dw),
      .tx_ready  (rdy),
      .serial_out(so),
      .busy      (bsy),
      .frame_done(dn)
    );

    // Model: a word becomes a queue of line bits; the first tick after
    // acceptance puts the start bit out, each later tick the next bit, and the
    // tick after the last stop bit ends the frame.
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        q.delete();
        m_busy  <= 1'b0;
        m_line  <= 1'b1;
        m_done  <= 1'b0;
        pop_cnt <= 0;
      end else begin
        m_done <= 1'b0;
        if (!m_busy) begin
          if (valid[gi]) begin
            for (int k = 0; k < frame_len(W, CP[gi], CS[gi]); k++)
              q.push_back(frame_bit(W, CP[gi], CS[gi], CM[gi], data, k));
            m_busy  <= 1'b1;
            acc_cnt <= acc_cnt + 8'd1;
            pop_cnt <= 0;
          end
        end else if (tick) begin
          if (q.size() != 0) begin
            m_line  <= q.pop_front();
            pop_cnt <= pop_cnt + 1;
          end else begin
            m_busy <= 1'b0;
            m_done <= 1'b1;
          end
        end
      end
    end

    assign so_v[gi]    = so;
    assign rdy_v[gi]   = rdy;
    assign bsy_v[gi]   = bsy;
    assign dn_v[gi]    = dn;
    assign eline_v[gi] = m_line;
    assign ebusy_v[gi] = m_busy;
    assign edone_v[gi] = m_done;
    assign acc_v[gi]   = acc_cnt;
  end

  initial begin
    forever begin
      @(negedge clk);
      if (tick_cnt + 1 >= tick_per) begin
        tick     = 1'b1;
        tick_cnt = 0;
      end else begin
        tick     = 1'b0;
        tick_cnt = tick_cnt + 1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < NCFG; i++) begin
        chk($sformatf("serial_out[%0d]", i), 32'(so_v[i]), 32'(eline_v[i]));
        chk($sformatf("tx_ready[%0d]", i), 32'(rdy_v[i]), 32'(!ebusy_v[i]));
        chk($sformatf("busy[%0d]", i), 32'(bsy_v[i]), 32'(ebusy_v[i]));
        chk($sformatf("frame_done[%0d]", i), 32'(dn_v[i]), 32'(edone_v[i]));
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (ebusy_v != '0 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait_in_budget", 32'(n < LIMIT), 32'd1);
  endtask

  task automatic send_all(input logic [8:0] word);
    wait_idle();
    valid = '1;
    data  = word;
    @(negedge clk);
    valid = '0;
  endtask

  initial begin
    int n;
    #1 rst = 1'b1;

    chk("model_default_a5", 32'(frame_bits(8, 0, 1, 0, 9'h0A5)), 32'h034A);
    chk("model_even_a5", 32'(frame_bits(8, 1, 1, 0, 9'h0A5)), 32'h054A);
    chk("model_odd_a5", 32'(frame_bits(8, 2, 1, 0, 9'h0A5)), 32'h074A);
    chk("model_msb_01_2stop", 32'(frame_bits(8, 0, 2, 1, 9'h001)), 32'h0700);
    chk("model_w5_13", 32'(frame_bits(5, 0, 1, 0, 9'h013)), 32'h0066);
    chk("model_default_0f", 32'(frame_bits(8, 0, 1, 0, 9'h00F)), 32'h021E);
    chk("model_len_default", 32'(frame_len(8, 0, 1)), 32'd10);
    chk("model_len_w5", 32'(frame_len(5, 0, 1)), 32'd7);
    chk("model_len_par_2stop", 32'(frame_len(9, 2, 2)), 32'd13);

    repeat (3) @(negedge clk);
    rst = 1'b0;

    tick_per = 4;
    send_all(9'h0A5);
    data = 9'h1FF;
    repeat (12) @(negedge clk);
    valid = '1;
    data  = 9'h03C;
    @(negedge clk);
    valid = '0;
    wait_idle();

    send_all(9'h001);
    send_all(9'h0F3);
    wait_idle();

    for (int i = 0; i < NCFG; i++) base_acc[i] = int'(acc_v[i]);
    valid = '1;
    data  = 9'h055;
    @(negedge clk);
    data = 9'h0AA;
    n = 0;
    while (valid != '0 && n < LIMIT) begin
      @(negedge clk);
      n++;
      for (int i = 0; i < NCFG; i++)
        if (int'(acc_v[i]) - base_acc[i] >= 2) valid[i] = 1'b0;
    end
    chk("back_to_back_in_budget", 32'(n < LIMIT), 32'd1);
    data = 9'h13C;
    wait_idle();

    tick_per = 1;
    send_all(9'h0A5);
    wait_idle();
    tick_per = 3;
    send_all(9'h05A);
    wait_idle();

    tick_per = 4;
    send_all(9'h0C3);
    n = 0;
    while (g_cfg[0].pop_cnt != 5 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk("reach_data_bit3", 32'(n < LIMIT), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_serial_out", 32'(so_v), 32'(6'h3F));
    chk("async_rst_tx_ready", 32'(rdy_v), 32'(6'h3F));
    chk("async_rst_busy", 32'(bsy_v), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send_all(9'h00F);
    wait_idle();
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
Parametrised framing serializer for the UART transmitter, replacing the bare load/shift PISO. It accepts a data word over a valid/ready handshake and emits a complete UART frame on serial_out: start bit, data, optional parity, and 1 or 2 stop bits. Bit timing comes from an external baud_tick enable generated by the transmitter's baud divider.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal 5..9.
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, number of stop bits; legal 1 or 2.
MSB_FIRST, 0, 0 = LSB first (UART standard), 1 = MSB first.

Ports:
tx_clk  input  1  single clock; all state changes on its rising edge.
rst  input  1  asynchronous, active-high reset.
baud_tick  input  1  one-cycle pulse per bit period.
tx_valid  input  1  tx_data is valid.
tx_data  input  DATA_WIDTH  word to transmit.
tx_ready  output  1  block can accept a word; high only in IDLE.
serial_out  output  1  UART line; idle high.
busy  output  1  high from acceptance until the frame ends.
frame_done  output  1  one-cycle pulse after the last stop bit.

Behaviour:
- Reset (async, immediate, also mid-frame): serial_out=1, tx_ready=1, busy=0, frame_done=0, state=IDLE, bit counter=0, shift register=0.
- All outputs are registered, or decoded from the registered state only.
- States: IDLE, ARM, START, DATA, PARITY, STOP.
- IDLE: tx_ready=1 and serial_out=1. baud_tick is ignored.
- Acceptance: tx_valid && tx_ready at a rising edge. On that edge, tx_data is latched into the shift register, parity is latched, and the state moves to ARM. tx_ready is 0 and busy is 1 from the next cycle.
- Parity value: even = XOR of the data bits; odd = inverted XOR.
- ARM: serial_out stays 1. On the next baud_tick, go to START and drive serial_out=0. This aligns the start bit to a full bit period.
- START: on baud_tick, go to DATA and drive the first data bit (bit 0, or bit DATA_WIDTH-1 if MSB_FIRST).
- DATA: on each baud_tick, drive the next bit and increment the bit counter.
  - After DATA_WIDTH bits have been held, go to PARITY if PARITY_MODE != 0, otherwise to STOP.
  - Shift direction is set by MSB_FIRST. The bit counter is $clog2(DATA_WIDTH+1) wide.
- PARITY: drive the latched parity bit for one period, then go to STOP on baud_tick.
- STOP: serial_out=1 for STOP_BITS periods, counted by baud_tick. On the tick that ends the last stop bit:
  - go to IDLE;
  - frame_done=1 for exactly one cycle;
  - busy=0 and tx_ready=1 in the same cycle.
- Every bit after ARM is held exactly one baud_tick interval.
- Frame length after ARM: 1 + DATA_WIDTH + (PARITY_MODE!=0) + STOP_BITS bit periods.
- Back-to-back: if tx_valid is high while frame_done is high, the next word is accepted on that edge. The line stays high through ARM, so no glitch occurs between frames.
- tx_data changes after acceptance have no effect. tx_valid while busy is ignored and not queued.
- A baud_tick on the acceptance edge itself is not counted. ARM waits for the next tick.
- baud_tick held high continuously gives a 1-cycle bit period; this must work.
- Illegal parameter values stop elaboration via a generate-time $error.

Test Plan:
- Defaults, baud_tick every 4 cycles, send 0xA5 -> after ARM, serial_out = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. frame_done pulses once, then tx_ready=1.
- PARITY_MODE=1, then 2, send 0xA5 -> parity bit 0 (even), 1 (odd), inserted between bit 7 and the stop bit.
- MSB_FIRST=1, send 0x01 -> data bits 0,0,0,0,0,0,0,1. STOP_BITS=2 -> line high for 8 cycles before frame_done.
- DATA_WIDTH=5, send 0x13 -> 0,1,1,0,0,1,1, a 7-period frame. Upper tx_data bits are ignored.
- tx_valid held high with 0x55 then 0xAA -> second accept occurs on the frame_done edge. Both frames are correct with no extra idle period. tx_data changes mid-frame do not corrupt the output.
- Assert rst during DATA bit 3 -> serial_out=1 and tx_ready=1 immediately (asynchronous). After release, a fresh 0x0F frame transmits correctly.
